// File: rtl/fuel_level_filter.sv
// Ultrasonic fuel-level filter: rejects bad echo samples, averages good ones over a
// power-of-two sliding window and converts the average to distance and level in mm.
module fuel_level_filter #(
  parameter int WIN_LOG2       = 2,
  parameter int SCALE_MUL      = 225,
  parameter int SCALE_SHIFT    = 16,
  parameter int TANK_HEIGHT_MM = 1500,
  parameter int MIN_COUNT      = 5000,
  parameter int FAULT_COUNT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] raw_count,
  input  logic        sample_strobe,
  input  logic        sample_timeout,
  output logic [15:0] distance_mm,
  output logic [15:0] level_mm,
  output logic        level_valid,
  output logic        window_full,
  output logic        fault
);

  localparam int DEPTH  = 1 << WIN_LOG2;
  localparam int SUM_W  = 21 + WIN_LOG2;
  localparam int FILL_W = WIN_LOG2 + 1;
  localparam int PROD_W = 37;
  localparam int BAD_W  = $clog2(FAULT_COUNT + 1);

  localparam logic [20:0]       MIN_C   = 21'(MIN_COUNT);
  localparam logic [FILL_W-1:0] DEPTH_C = FILL_W'(DEPTH);
  localparam logic [BAD_W-1:0]  FAULT_C = BAD_W'(FAULT_COUNT);
  localparam logic [PROD_W-1:0] MUL_C   = PROD_W'(SCALE_MUL);
  localparam logic [PROD_W-1:0] SAT_C   = PROD_W'(16'hFFFF);
  localparam logic [15:0]       TANK_C  = 16'(TANK_HEIGHT_MM);

  typedef enum logic {FILL, RUN} state_t;

  state_t              state;
  logic [20:0]         window [DEPTH];
  logic [WIN_LOG2-1:0] wr_ptr;
  logic [FILL_W-1:0]   fill;
  logic [SUM_W-1:0]    sum;
  logic [BAD_W-1:0]    bad_cnt;
  logic                v1, v2;
  logic [PROD_W-1:0]   prod;

  logic                good, bad, full_next;
  logic [20:0]         oldest;
  logic [FILL_W-1:0]   fill_next;
  logic [BAD_W-1:0]    bad_next;
  logic [PROD_W-1:0]   shifted;
  logic [15:0]         dist_sat, level_calc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    good       = sample_strobe && !sample_timeout && (raw_count >= MIN_C);
    bad        = sample_strobe && !good;
    oldest     = (fill == DEPTH_C) ? window[wr_ptr] : '0;
    fill_next  = (fill == DEPTH_C) ? fill : fill + FILL_W'(1);
    full_next  = (fill_next == DEPTH_C);
    bad_next   = (bad_cnt == FAULT_C) ? bad_cnt : bad_cnt + BAD_W'(1);
    shifted    = prod >> SCALE_SHIFT;
    dist_sat   = (shifted > SAT_C) ? 16'hFFFF : shifted[15:0];
    level_calc = (dist_sat >= TANK_C) ? 16'd0 : TANK_C - dist_sat;
  end

  assign window_full = (state == RUN);

  // Stage 1: window, running sum, fill/fault bookkeeping and the FILL/RUN state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the window is cleared on reset so the running sum never subtracts stale data.
      for (int i = 0; i < DEPTH; i++) window[i] <= '0;
      state   <= FILL;
      wr_ptr  <= '0;
      fill    <= '0;
      sum     <= '0;
      bad_cnt <= '0;
      fault   <= 1'b0;
      v1      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
      v1 <= good && full_next;
      if (good) begin
        window[wr_ptr] <= raw_count;
        wr_ptr         <= wr_ptr + WIN_LOG2'(1);
        sum            <= sum + SUM_W'(raw_count) - SUM_W'(oldest);
        fill           <= fill_next;
        bad_cnt        <= '0;
        fault          <= 1'b0;
        if (state == FILL && full_next) state <= RUN;
      end else if (bad) begin
        bad_cnt <= bad_next;
        fault   <= (bad_next == FAULT_C);
      end
    end
  end

  // Stages 2 and 3: average and scale, then saturate and convert to level.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2          <= 1'b0;
      prod        <= '0;
      distance_mm <= '0;
      level_mm    <= '0;
      level_valid <= 1'b0;
    end else begin
      v2          <= v1;
      prod        <= PROD_W'(sum[SUM_W-1:WIN_LOG2]) * MUL_C;
      level_valid <= v2;
      if (v2) begin
        distance_mm <= dist_sat;
        level_mm    <= level_calc;
      end
    end
  end

endmodule

// File: tb/tb_fuel_level_filter.sv
// Self-checking bench for fuel_level_filter: directed vector table, back-to-back and
// mid-pipeline reset sequences, then random traffic against a queue-based reference model.
module tb_fuel_level_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [20:0] raw_count = '0;
  logic        sample_strobe = 1'b0;
  logic        sample_timeout = 1'b0;
  logic [15:0] distance_mm, level_mm;
  logic        level_valid, window_full, fault;

  fuel_level_filter dut (
    .clk            (clk),
    .rst            (rst),
    .raw_count      (raw_count),
    .sample_strobe  (sample_strobe),
    .sample_timeout (sample_timeout),
    .distance_mm    (distance_mm),
    .level_mm       (level_mm),
    .level_valid    (level_valid),
    .window_full    (window_full),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          do_rst;
    int unsigned count;
    bit          tmo;
    bit          exp_lv;
    int unsigned exp_dist;
    int unsigned exp_level;
    bit          exp_fault;
    bit          exp_full;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, int unsigned c, bit t, bit lv, int unsigned d,
                              int unsigned l, bit f, bit full);
    vec_t v;
    v.do_rst = r; v.count = c; v.tmo = t; v.exp_lv = lv;
    v.exp_dist = d; v.exp_level = l; v.exp_fault = f; v.exp_full = full;
    vecs.push_back(v);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " distance"}, distance_mm, 0);
    check({tag, " level"}, level_mm, 0);
    check({tag, " valid"}, level_valid, 0);
    check({tag, " full"}, window_full, 0);
    check({tag, " fault"}, fault, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_strobe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");
  endtask

  // One isolated strobe; the pulse must land exactly on the third cycle afterwards.
  task automatic apply_vec(input vec_t v, input int idx);
    int hits = 0;
    int at = -1;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.do_rst) do_reset();
    @(negedge clk);
    sample_strobe  = 1'b1;
    raw_count      = 21'(v.count);
    sample_timeout = v.tmo;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, " fault"}, fault, v.exp_fault);
        check({tag, " full"}, window_full, v.exp_full);
      end
      if (level_valid) begin
        hits++;
        at = k;
      end
      // Idle-cycle inputs carry junk that must be ignored.
      sample_strobe  = 1'b0;
      raw_count      = 21'($urandom);
      sample_timeout = 1'($urandom);
    end
    check({tag, " valid pulses"}, hits, v.exp_lv);
    if (v.exp_lv) check({tag, " valid latency"}, at, 3);
    check({tag, " distance"}, distance_mm, v.exp_dist);
    check({tag, " level"}, level_mm, v.exp_level);
  endtask

  task automatic back_to_back(input bit with_rst);
    int hits = 0;
    int at = -1;
    string tag;
    tag = with_rst ? "b2b_rst" : "b2b";
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_strobe  = 1'b1;
      raw_count      = 21'd291545;
      sample_timeout = 1'b0;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (level_valid) begin
        hits++;
        at = k;
      end
      sample_strobe = 1'b0;
      if (with_rst && k == 2) rst = 1'b1;
      if (with_rst && k == 3) rst = 1'b0;
    end
    if (with_rst) begin
      check({tag, " valid pulses"}, hits, 0);
      check_all_zero(tag);
    end else begin
      check({tag, " valid pulses"}, hits, 1);
      check({tag, " valid latency"}, at, 3);
      check({tag, " distance"}, distance_mm, 1000);
      check({tag, " level"}, level_mm, 500);
      check({tag, " full"}, window_full, 1);
    end
  endtask

  // Reference model: distance from the mean of the last four accepted samples.
  function automatic longint model_dist(input longint win[$]);
    longint s = 0;
    longint d;
    foreach (win[i]) s += win[i];
    d = ((s / 4) * 225) / 65536;
    return (d > 65535) ? 65535 : d;
  endfunction

  typedef struct {
    bit     v;
    longint d;
    longint l;
  } ev_t;

  task automatic random_run(input int cycles);
    longint win[$];
    ev_t    ev[$];
    ev_t    e;
    int     mbad = 0;
    longint m_dist = 0, m_level = 0;
    bit     exp_lv;
    bit     stb, tmo;
    int unsigned cnt;
    int     sel;
    do_reset();
    e.v = 1'b0; e.d = 0; e.l = 0;
    for (int i = 0; i < 3; i++) ev.push_front(e);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      e = ev.pop_back();
      exp_lv = e.v;
      if (e.v) begin
        m_dist  = e.d;
        m_level = e.l;
      end
      check("rand valid", level_valid, exp_lv);
      check("rand distance", distance_mm, m_dist);
      check("rand level", level_mm, m_level);
      check("rand fault", fault, (mbad >= 3) ? 1 : 0);
      check("rand full", window_full, (win.size() == 4) ? 1 : 0);

      stb = ($urandom_range(0, 2) != 0);
      tmo = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       cnt = $urandom_range(4990, 5010);
        1:       cnt = $urandom_range(0, 4999);
        2:       cnt = 21'h1FFFFF;
        default: cnt = $urandom_range(5000, 700000);
      endcase
      sample_strobe  = stb;
      sample_timeout = tmo;
      raw_count      = 21'(cnt);

      e.v = 1'b0; e.d = 0; e.l = 0;
      if (stb) begin
        if (!tmo && cnt >= 5000) begin
          win.push_back(cnt);
          if (win.size() > 4) void'(win.pop_front());
          mbad = 0;
          if (win.size() == 4) begin
            e.v = 1'b1;
            e.d = model_dist(win);
            e.l = (e.d >= 1500) ? 0 : 1500 - e.d;
          end
        end else if (mbad < 3) begin
          mbad++;
        end
      end
      ev.push_front(e);
    end
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  initial begin
    //  rst  count   tmo lv  dist  level fault full
    add(1, 291545, 0, 0,    0,    0, 0, 0);
    add(0, 291545, 0, 0,    0,    0, 0, 0);
    add(0, 291545, 0, 0,    0,    0, 0, 0);
    add(0, 291545, 0, 1, 1000,  500, 0, 1);
    add(1, 100000, 0, 0,    0,    0, 0, 0);
    add(0, 200000, 0, 0,    0,    0, 0, 0);
    add(0, 300000, 0, 0,    0,    0, 0, 0);
    add(0, 400000, 0, 1,  858,  642, 0, 1);
    add(0, 500000, 0, 1, 1201,  299, 0, 1);
    add(0, 500000, 0, 1, 1459,   41, 0, 1);
    add(0, 500000, 0, 1, 1630,    0, 0, 1);
    add(0, 500000, 0, 1, 1716,    0, 0, 1);
    add(0, 500000, 0, 1, 1716,    0, 0, 1);
    add(0, 300000, 1, 0, 1716,    0, 0, 1);
    add(0, 300000, 1, 0, 1716,    0, 0, 1);
    add(0, 300000, 1, 0, 1716,    0, 1, 1);
    add(0,   1000, 0, 0, 1716,    0, 1, 1);
    add(0, 291545, 0, 1, 1537,    0, 0, 1);
    add(0,   4999, 0, 0, 1537,    0, 0, 1);
    add(0,   5000, 0, 1, 1112,  388, 0, 1);

    foreach (vecs[i]) apply_vec(vecs[i], i);

    back_to_back(1'b0);
    back_to_back(1'b1);

    random_run(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
